des_round_sequencer: RTL and testbench
======================================

// Module: des_round_sequencer
// PURPOSE
//  Iterative DES round controller. Holds the L/R half-blocks and the 56-bit C/D key state.
//  Runs one round per cycle through an external combinational f-function datapath:
//  expansion, subkey XOR, S-boxes and P permutation, with PC-2 applied to F_CD on the datapath side.
//  Sits between the IP/PC-1 front end and the FP back end.
//  Supports START/BUSY/DONE handshake and encrypt/decrypt key-schedule direction.
// PARAMETERS
//  ROUNDS  16  rounds executed; legal range 1..16. Values <16 are for reduced-round debug only;
//              schedule uses the first ROUNDS entries.
//  CW      4   round-counter width; must satisfy 2**CW >= ROUNDS.
// PORTS
//  CLK       in   1    clock; all state updates on the rising edge
//  RST       in   1    synchronous, active-low reset
//  START     in   1    request; sampled only in IDLE or DONE
//  DECRYPT   in   1    direction, sampled with START (1 = decrypt)
//  DATA_IN   in   64   post-IP block; [64:33] = L0, [32:1] = R0
//  KEY_CD    in   56   post-PC-1 key; [56:29] = C0, [28:1] = D0
//  F_OUT     in   32   f(R, K) returned by the round datapath, same cycle
//  F_RIGHT   out  32   current R fed to the datapath
//  F_CD      out  56   current C/D fed to PC-2 / the datapath
//  BUSY      out  1    high in RUN
//  DONE      out  1    one-cycle pulse: DATA_OUT is valid
//  DATA_OUT  out  64   pre-FP result {R16, L16}; held until the next DONE
//  ABORT     in   1    present only with DES_SEQ_ABORT_EN
// BEHAVIOUR
//  FSM states:
//   IDLE -> RUN on START.
//   RUN  -> DONE when cnt == ROUNDS-1.
//   DONE -> RUN on START, else IDLE.
//  Accepting START: L <= DATA_IN[64:33]; R <= DATA_IN[32:1]; cnt <= 0; dir <= DECRYPT.
//   Encrypt: CD <= rotl28 of each half by s[1]. Decrypt: CD <= KEY_CD unrotated.
//  Each RUN cycle: L <= R; R <= L ^ F_OUT; cnt <= cnt+1.
//   CD is updated for the next round i = cnt+2:
//   encrypt: rotl by s[i]; decrypt: rotr by s[18-i].
//   C and D rotate independently as 28-bit fields.
//  Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//  Leaving RUN: DATA_OUT <= {R_new, L_new} (final swap); DONE = 1 in the DONE state only.
//  Latency: START sampled at edge 0; rounds occupy edges 1..ROUNDS; DONE is high the cycle after edge ROUNDS
//   (17 cycles for 16 rounds). Back-to-back throughput is one block per ROUNDS+1 cycles.
//  F_RIGHT = R and F_CD = CD at all times; the datapath must settle within one cycle.
//  START while BUSY: ignored, no queueing. DECRYPT and DATA_IN are ignored outside the accept cycle.
//  Reset, including mid-operation: state IDLE, BUSY=0, DONE=0, DATA_OUT=0, L=R=0, CD=0, cnt=0.
//   Any in-flight block is discarded.
//  START in the DONE cycle: DONE still pulses; the new block loads at the same edge.
// CONFIGURATION
//  DES_SEQ_ABORT_EN defined: ABORT port exists.
//   ABORT in RUN -> IDLE at the next edge; no DONE; DATA_OUT keeps its old value.
//   ABORT in IDLE/DONE has priority over START (START is dropped).
//  DES_SEQ_ABORT_EN undefined: no ABORT port; RUN always completes.
// STRUCTURE
//  Package des_seq_pkg:
//   state enum {IDLE, RUN, DONE};
//   SHIFT_SCHED constant (16 x 2-bit);
//   rotl28/rotr28 functions.
//  One sub-module: des_key_rotator (combinational; CD, amount, dir -> next CD).
//  The FSM, counter and L/R registers stay in the top level.
// TESTING
//  FIPS vector, key 133457799BBCDFF1, pt 0123456789ABCDEF, encrypt, bench-side IP/PC-1/f/FP:
//   after FP -> 85E813540F0AB405; DONE exactly 17 cycles after START.
//  Decrypt the same ct with the same key: -> 0123456789ABCDEF; F_CD in the first RUN cycle == KEY_CD.
//  Key-schedule check: F_CD in each RUN cycle matches the model for rounds 1..16.
//   Encrypt CD after round 16 == KEY_CD (total rotation 28).
//  Pulse START at cycle 5 of RUN: ignored; result and DONE timing unchanged.
//   Then START in the DONE cycle: second block DONE 17 cycles later.
//  RST low at round 8: next cycle BUSY=0, DONE=0, DATA_OUT=0.
//   A subsequent START yields a correct result.
//  With DES_SEQ_ABORT_EN: ABORT at round 4 -> IDLE, no DONE, DATA_OUT retains the previous result.
//   ABORT+START in IDLE -> stays IDLE.

Source files
------------

// File: rtl/des_seq_pkg.sv
// Shared types and helpers for the iterative DES round sequencer:
// FSM state encoding, the per-round key shift schedule and 28-bit rotations.
package des_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Left-shift amounts s[1..16]; entry 0 holds s[1].
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Shift amount for 1-based round index i; zero outside 1..16.
    function automatic logic [1:0] sched_shift(input int i);
        if (i < 1 || i > 16) return 2'd0;
        return SHIFT_SCHED[4'(i - 1)];
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            2'd3:    return {x[24:0], x[27:25]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            2'd3:    return {x[2:0], x[27:3]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_round_sequencer_if.sv
// Handshake and datapath bundle between the DES front/back end, the external
// f-function datapath and the round sequencer. The abort line exists only
// when DES_SEQ_ABORT_EN is defined.
interface des_round_sequencer_if;
    logic        start;
    logic        decrypt;
    logic [63:0] data_in;
    logic [55:0] key_cd;
    logic [31:0] f_out;
    logic [31:0] f_right;
    logic [55:0] f_cd;
    logic        busy;
    logic        done;
    logic [63:0] data_out;
`ifdef DES_SEQ_ABORT_EN
    logic        abort;
`endif

    modport master (
        output start, decrypt, data_in, key_cd, f_out,
`ifdef DES_SEQ_ABORT_EN
        output abort,
`endif
        input  f_right, f_cd, busy, done, data_out
    );

    modport slave (
        input  start, decrypt, data_in, key_cd, f_out,
`ifdef DES_SEQ_ABORT_EN
        input  abort,
`endif
        output f_right, f_cd, busy, done, data_out
    );
endinterface

// File: rtl/des_key_rotator.sv
// Combinational C/D key-state rotator: C and D rotate independently as
// 28-bit halves, left for the encrypt schedule and right for decrypt.
module des_key_rotator
    import des_seq_pkg::*;
(
    input  logic [55:0] cd,
    input  logic [1:0]  amount,
    input  logic        rot_right,
    output logic [55:0] cd_next
);

    // Rotate both halves by the same amount in the requested direction.
    always_comb begin
        cd_next = cd;
        if (rot_right) begin
            cd_next = {rotr28(cd[55:28], amount), rotr28(cd[27:0], amount)};
        end else begin
            cd_next = {rotl28(cd[55:28], amount), rotl28(cd[27:0], amount)};
        end
    end

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: holds L/R and C/D, runs one round per cycle
// through an external f-function, and presents {R16, L16} with a DONE pulse.
// Optional feature: define DES_SEQ_ABORT_EN to add the abort input.
module des_round_sequencer
    import des_seq_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int CW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    des_round_sequencer_if.slave bus
);

    state_t          state_q, state_d;
    logic [31:0]     l_q, r_q;
    logic [55:0]     cd_q;
    logic [CW-1:0]   cnt_q;
    logic            dir_q;
    logic [63:0]     dout_q;

    logic            abort_req;
    logic            accept;
    logic            last_round;
    logic [31:0]     r_new;
    logic [1:0]      run_amt;
    logic [55:0]     rot_in;
    logic [1:0]      rot_amt;
    logic            rot_right;
    logic [55:0]     cd_next;

`ifdef DES_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // A new block is taken in IDLE or DONE; abort drops a coincident start.
    assign accept     = (state_q != RUN) && bus.start && !abort_req;
    assign last_round = (cnt_q == CW'(ROUNDS - 1));
    assign r_new      = l_q ^ bus.f_out;

    // Prepare the key for round cnt+2: encrypt uses s[cnt+2], decrypt s[16-cnt].
    // The final encrypt step gets zero so C/D ends at a full 28-bit rotation.
    assign run_amt   = dir_q ? sched_shift(16 - int'(cnt_q)) : sched_shift(int'(cnt_q) + 2);
    assign rot_in    = accept ? bus.key_cd : cd_q;
    assign rot_amt   = accept ? (bus.decrypt ? 2'd0 : sched_shift(1)) : run_amt;
    assign rot_right = accept ? 1'b0 : dir_q;

    des_key_rotator u_rot (
        .cd        (rot_in),
        .amount    (rot_amt),
        .rot_right (rot_right),
        .cd_next   (cd_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: run ROUNDS rounds, pulse DONE once, allow back-to-back starts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN: begin
                if (abort_req)       state_d = IDLE;
                else if (last_round) state_d = DONE;
            end
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Block load, per-round Feistel update and final swapped result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            l_q    <= '0;
            r_q    <= '0;
            cd_q   <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            dout_q <= '0;
        end else if (accept) begin
            l_q   <= bus.data_in[63:32];
            r_q   <= bus.data_in[31:0];
            cd_q  <= cd_next;
            cnt_q <= '0;
            dir_q <= bus.decrypt;
        end else if (state_q == RUN && !abort_req) begin
            l_q   <= r_q;
            r_q   <= r_new;
            cd_q  <= cd_next;
            cnt_q <= cnt_q + 1'b1;
            if (last_round) dout_q <= {r_new, r_q};
        end
    end

    assign bus.f_right  = r_q;
    assign bus.f_cd     = cd_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Testbench for des_round_sequencer: supplies IP/PC-1/PC-2/f/FP on the bench
// side, tracks a whole-block DES model and compares the DUT every cycle.
// Abort scenarios are built only when DES_SEQ_ABORT_EN is defined.
module tb_des_round_sequencer;

    localparam int R = 16;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                  62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                  57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                   10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                   16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                   44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        int row, col;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[31-4*b -: 4] = 4'(SB[b][row*16+col]);
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    // Cumulative left rotation of the C/D halves before round k.
    function automatic logic [55:0] cd_for(input logic [55:0] key, input int k);
        int n;
        logic [27:0] c, d;
        n = 0;
        for (int j = 0; j < k; j++) n += SHIFTS[j];
        c = key[55:28];
        d = key[27:0];
        c = 28'((c << n) | (c >> (28 - n)));
        d = 28'((d << n) | (d >> (28 - n)));
        return {c, d};
    endfunction

    logic clk = 1'b0;
    logic rst;
    des_round_sequencer_if dif();

    des_round_sequencer #(.ROUNDS(R), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    // Bench-side round datapath: PC-2 on the key state, then f(R, K).
    assign dif.f_out = des_f(dif.f_right, pc2(dif.f_cd));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: phase 0 = idle, 1..R = round k in progress, R+1 = done cycle.
    logic [31:0] exp_l [0:16];
    logic [31:0] exp_r [0:16];
    logic [55:0] exp_cd [1:16];
    logic [55:0] m_key;
    logic [63:0] m_out = '0;
    int          m_phase = 0;
    bit          m_seen_rst = 0;

    always @(posedge clk) begin : model
        bit acc, ab;
        ab = 1'b0;
`ifdef DES_SEQ_ABORT_EN
        ab = dif.abort;
`endif
        if (!rst) begin
            m_seen_rst = 1'b1;
            m_phase    = 0;
            m_out      = '0;
        end else begin
            acc = dif.start && (m_phase == 0 || m_phase == R + 1) && !ab;
            if (ab && m_phase >= 1 && m_phase <= R) begin
                m_phase = 0;
            end else if (acc) begin
                m_key    = dif.key_cd;
                exp_l[0] = dif.data_in[63:32];
                exp_r[0] = dif.data_in[31:0];
                for (int k = 1; k <= 16; k++) begin
                    exp_cd[k] = dif.decrypt ? cd_for(dif.key_cd, 17 - k) : cd_for(dif.key_cd, k);
                    exp_l[k]  = exp_r[k-1];
                    exp_r[k]  = exp_l[k-1] ^ des_f(exp_r[k-1], pc2(exp_cd[k]));
                end
                m_phase = 1;
            end else if (m_phase >= 1 && m_phase < R) begin
                m_phase++;
            end else if (m_phase == R) begin
                m_phase = R + 1;
                m_out   = {exp_r[R], exp_l[R]};
            end else begin
                m_phase = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_seen_rst) begin
            chk("busy", 64'(dif.busy), 64'(m_phase >= 1 && m_phase <= R));
            chk("done", 64'(dif.done), 64'(m_phase == R + 1));
            chk("data_out", dif.data_out, m_out);
            if (m_phase >= 1 && m_phase <= R) begin
                chk("f_right", 64'(dif.f_right), 64'(exp_r[m_phase-1]));
                chk("f_cd", 64'(dif.f_cd), 64'(exp_cd[m_phase]));
            end else if (m_phase == R + 1) begin
                chk("f_right_final", 64'(dif.f_right), 64'(exp_r[R]));
                chk("f_cd_final", 64'(dif.f_cd), 64'(m_key));
            end
        end
    end

    // Run one block; optionally pulse START again pulse_at cycles into RUN.
    task automatic do_block(input logic [63:0] din, input logic [55:0] key, input bit dec,
                            input int pulse_at, output logic [63:0] res,
                            output logic [55:0] cd1, output logic [31:0] r1, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        cd1 = '0;
        r1  = '0;
        dif.start   = 1'b1;
        dif.data_in = din;
        dif.key_cd  = key;
        dif.decrypt = dec;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            dif.start   = 1'b0;
            dif.data_in = ~din;
            dif.decrypt = ~dec;
            if (lat == 1) begin
                cd1 = dif.f_cd;
                r1  = dif.f_right;
            end
            if (lat == pulse_at) begin
                dif.start   = 1'b1;
                dif.data_in = 64'h5555_AAAA_1234_5678;
            end
            if (dif.done) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'(1));
        res = dif.data_out;
    endtask

    localparam logic [63:0] KEY1 = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] PT1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CT1  = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] KEY2 = 64'h0E32_9232_EA6D_0D73;
    localparam logic [63:0] PT2  = 64'h8787_8787_8787_8787;

    initial begin : main
        logic [63:0] res, prev;
        logic [55:0] cd1, kcd1, kcd2;
        logic [31:0] r1;
        int lat, dcnt;

        rst = 1'b0;
        dif.start = 1'b0;
        dif.decrypt = 1'b0;
        dif.data_in = '0;
        dif.key_cd = '0;
`ifdef DES_SEQ_ABORT_EN
        dif.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(dif.busy), 64'(0));
        chk("rst_done", 64'(dif.done), 64'(0));
        chk("rst_data_out", dif.data_out, 64'h0);
        chk("rst_f_right", 64'(dif.f_right), 64'h0);
        chk("rst_f_cd", 64'(dif.f_cd), 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        kcd1 = pc1(KEY1);
        kcd2 = pc1(KEY2);
        chk("ip_pin", ip(PT1), 64'hCC00_CCFF_F0AA_F0AA);
        chk("pc1_pin", 64'(kcd1), 64'h00F0_CCAA_F556_678F);

        // FIPS encrypt.
        do_block(ip(PT1), kcd1, 1'b0, 0, res, cd1, r1, lat);
        chk("enc_ct", fp(res), CT1);
        chk("enc_latency", 64'(lat), 64'(17));
        chk("enc_k1", 64'(pc2(cd1)), 64'h1B02_EFFC_7072);
        chk("enc_r0", 64'(r1), 64'hF0AA_F0AA);
        repeat (2) @(posedge clk);
        #1;

        // Decrypt the same ciphertext with the same key.
        do_block(ip(CT1), kcd1, 1'b1, 0, res, cd1, r1, lat);
        chk("dec_pt", fp(res), PT1);
        chk("dec_latency", 64'(lat), 64'(17));
        chk("dec_first_cd", 64'(cd1), 64'(kcd1));
        @(posedge clk);
        #1;

        // Second known vector encrypts to all zeros.
        do_block(ip(PT2), kcd2, 1'b0, 0, res, cd1, r1, lat);
        chk("enc2_ct", fp(res), 64'h0);
        repeat (3) @(posedge clk);
        #1;

        // START during RUN is ignored; then START in the DONE cycle chains a block.
        do_block(ip(PT1), kcd1, 1'b0, 5, res, cd1, r1, lat);
        chk("pulse_ct", fp(res), CT1);
        chk("pulse_latency", 64'(lat), 64'(17));
        do_block(ip(64'h0), kcd2, 1'b1, 0, res, cd1, r1, lat);
        chk("b2b_dec_pt", fp(res), PT2);
        chk("b2b_latency", 64'(lat), 64'(17));
        @(posedge clk);
        #1;

`ifdef DES_SEQ_ABORT_EN
        // Abort at round 4: no DONE, previous result retained.
        prev = dif.data_out;
        dif.start = 1'b1;
        dif.data_in = ip(PT1);
        dif.key_cd = kcd1;
        dif.decrypt = 1'b0;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        dif.abort = 1'b1;
        @(posedge clk);
        #1;
        dif.abort = 1'b0;
        chk("abort_busy", 64'(dif.busy), 64'(0));
        dcnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (dif.done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'(0));
        chk("abort_keeps_out", dif.data_out, prev);
        // Abort together with START in IDLE keeps the sequencer idle.
        dif.abort = 1'b1;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.abort = 1'b0;
        dif.start = 1'b0;
        chk("abort_start_idle", 64'(dif.busy), 64'(0));
        @(posedge clk);
        #1;
        chk("abort_start_idle2", 64'(dif.busy), 64'(0));
`endif

        // Reset at round 8 discards the block.
        dif.start = 1'b1;
        dif.data_in = ip(PT1);
        dif.key_cd = kcd1;
        dif.decrypt = 1'b0;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy_before_rst", 64'(dif.busy), 64'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 64'(dif.busy), 64'(0));
        chk("mid_rst_done", 64'(dif.done), 64'(0));
        chk("mid_rst_data_out", dif.data_out, 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_block(ip(PT1), kcd1, 1'b0, 0, res, cd1, r1, lat);
        chk("post_rst_ct", fp(res), CT1);
        chk("post_rst_latency", 64'(lat), 64'(17));
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit exceeded");
    end

endmodule
